// File: rtl/qos_pkg.sv
// Shared constants, FSM encoding and round-robin pick helper for the QoS VC arbiter.
package qos_pkg;

  localparam int N_VC = 4;
  localparam logic [15:0] QOS_DEF_WGT = {4'd4, 4'd3, 4'd2, 4'd1};

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Walk the offsets from high to low so the smallest offset from start wins.
  function automatic pick_t next_eligible(input logic [N_VC-1:0] mask, input logic [1:0] start);
    pick_t      r;
    logic [1:0] cand;
    r = '0;
    for (int k = N_VC - 1; k >= 0; k--) begin
      cand = start + 2'(k);
      if (mask[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/qos_rr_picker.sv
// Rotate-priority encoder: first set bit of eligible_i at or after start_i, wrapping.
// Purely combinational, no backpressure.
module qos_rr_picker
  import qos_pkg::*;
(
  input  logic [N_VC-1:0] eligible_i,
  input  logic [1:0]      start_i,
  output logic            found_o,
  output logic [1:0]      idx_o
);

  pick_t pick;

  always_comb begin
    pick = next_eligible(eligible_i, start_i);
  end

  assign found_o = pick.found;
  assign idx_o   = pick.idx;

endmodule

// File: rtl/qos_vc_arbiter.sv
// Weighted round-robin drain of four VC FIFOs into one downstream FIFO; pop->push latency 2.
// Downstream full/almost-full stalls pops while holding the current VC and its remaining credit.
module qos_vc_arbiter
  import qos_pkg::*;
#(
  parameter int                 DATA_W  = 6,
  parameter int                 WGT_W   = 4,
  parameter logic [4*WGT_W-1:0] DEF_WGT = QOS_DEF_WGT
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic [3:0]          EMPTY_IN,
  input  logic [3:0]          ALMOST_EMPTY_IN,
  input  logic                DST_FULL,
  input  logic                DST_ALMOST_FULL,
  input  logic [4*DATA_W-1:0] data_in,
  input  logic                cfg_load,
  input  logic [4*WGT_W-1:0]  cfg_weights,
  output logic [3:0]          pop,
  output logic                push_out,
  output logic [DATA_W-1:0]   data_out,
  output logic [1:0]          active_vc,
  output logic                busy
);

  state_e            state_q, state_d;
  logic [1:0]        vc_q, vc_d;
  logic [WGT_W-1:0]  credit_q, credit_d;
  logic [WGT_W-1:0]  wgt_q [N_VC];
  logic [N_VC-1:0]   pop_q, pop_d;
  logic              pd_q;
  logic [1:0]        sel_q;
  logic              push_q;
  logic [DATA_W-1:0] dat_q;

  logic [N_VC-1:0]   elig;
  logic [DATA_W-1:0] din_vc [N_VC];
  logic              bp;
  logic              pick_found;
  logic [1:0]        pick_idx;
  logic              load;
  logic              serve_pop;

  assign bp = DST_ALMOST_FULL | DST_FULL;

  // A VC that is almost empty and was popped last cycle may already be drained;
  // its flags lag by one cycle, so it sits out this cycle.
  always_comb begin
    elig = '0;
    for (int n = 0; n < N_VC; n++) begin
      elig[n]   = !EMPTY_IN[n] && (wgt_q[n] != '0) && !(ALMOST_EMPTY_IN[n] && pop_q[n]);
      din_vc[n] = data_in[n*DATA_W +: DATA_W];
    end
  end

  qos_rr_picker u_picker (
    .eligible_i (elig),
    .start_i    (vc_q + 2'd1),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  assign load      = (state_q == IDLE) && pick_found && !bp;
  assign serve_pop = (state_q == SERVE) && elig[vc_q] && !bp && (credit_q != '0);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SERVE;
      SERVE:   if (!elig[vc_q] || (serve_pop && credit_q == WGT_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vc_d     = vc_q;
    credit_d = credit_q;
    pop_d    = '0;
    if (load) begin
      vc_d     = pick_idx;
      credit_d = wgt_q[pick_idx];
    end
    if (serve_pop) begin
      pop_d[vc_q] = 1'b1;
      credit_d    = credit_q - WGT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      vc_q     <= 2'd3;
      credit_q <= '0;
      pop_q    <= '0;
    end else begin
      vc_q     <= vc_d;
      credit_q <= credit_d;
      pop_q    <= pop_d;
    end
  end

  // Weights change immediately but only reach the credit counter on the next load.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int n = 0; n < N_VC; n++) wgt_q[n] <= DEF_WGT[n*WGT_W +: WGT_W];
    end else if (cfg_load) begin
      for (int n = 0; n < N_VC; n++) wgt_q[n] <= cfg_weights[n*WGT_W +: WGT_W];
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pd_q   <= 1'b0;
      sel_q  <= '0;
      push_q <= 1'b0;
      dat_q  <= '0;
    end else begin
      pd_q   <= |pop_q;
      sel_q  <= vc_q;
      push_q <= pd_q;
      dat_q  <= din_vc[sel_q];
    end
  end

  always @(posedge clk) begin
    if (reset_L && serve_pop) assert (credit_q != '0);
  end

  assign pop       = pop_q;
  assign push_out  = push_q;
  assign data_out  = dat_q;
  assign active_vc = vc_q;
  assign busy      = (state_q == SERVE);

endmodule

// File: tb/tb_qos_vc_arbiter.sv
// Bench for qos_vc_arbiter: FIFO bank model, rule-level scheduler model and data scoreboard.
module tb_qos_vc_arbiter;

  localparam int DW = 6;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          reset_L = 1'b1;
  logic [3:0]    EMPTY_IN = 4'hF;
  logic [3:0]    ALMOST_EMPTY_IN = 4'hF;
  logic          DST_FULL = 1'b0;
  logic          DST_ALMOST_FULL = 1'b0;
  logic [4*DW-1:0] data_in = '0;
  logic          cfg_load = 1'b0;
  logic [4*WW-1:0] cfg_weights = '0;
  logic [3:0]    pop;
  logic          push_out;
  logic [DW-1:0] data_out;
  logic [1:0]    active_vc;
  logic          busy;

  qos_vc_arbiter #(.DATA_W(DW), .WGT_W(WW), .DEF_WGT(16'h4321)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .EMPTY_IN        (EMPTY_IN),
    .ALMOST_EMPTY_IN (ALMOST_EMPTY_IN),
    .DST_FULL        (DST_FULL),
    .DST_ALMOST_FULL (DST_ALMOST_FULL),
    .data_in         (data_in),
    .cfg_load        (cfg_load),
    .cfg_weights     (cfg_weights),
    .pop             (pop),
    .push_out        (push_out),
    .data_out        (data_out),
    .active_vc       (active_vc),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // VC FIFO bank as circular buffers
  logic [DW-1:0] mem [4][64];
  int            head [4];
  int            cnt  [4];
  logic [DW-1:0] rd_word [4];
  logic [DW-1:0] exp_q [$];
  logic [3:0]    seen_pop = 4'h0;

  // Scheduler reference model state
  bit         m_serve;
  int         m_vc;
  int         m_credit;
  int         m_w [4];
  logic [3:0] m_pop;
  bit         m_pd;
  bit         m_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int vc_of(input logic [3:0] p);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (p[i]) r = i;
    return r;
  endfunction

  task automatic drive_fifo();
    for (int v = 0; v < 4; v++) begin
      EMPTY_IN[v]        = (cnt[v] == 0);
      ALMOST_EMPTY_IN[v] = (cnt[v] <= 1);
      data_in[v*DW +: DW] = rd_word[v];
    end
  endtask

  task automatic fill(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      mem[v][(head[v] + cnt[v]) % 64] = DW'($urandom_range(0, 63));
      cnt[v]++;
    end
    drive_fifo();
  endtask

  task automatic clear_fifos();
    for (int v = 0; v < 4; v++) cnt[v] = 0;
    drive_fifo();
  endtask

  task automatic model_reset();
    m_serve = 0; m_vc = 3; m_credit = 0;
    m_w[0] = 1; m_w[1] = 2; m_w[2] = 3; m_w[3] = 4;
    m_pop = 4'h0; m_pd = 0; m_push = 0;
  endtask

  // One clock of the scheduling rules, using the inputs the DUT sampled at that edge.
  task automatic model_step();
    bit         bp;
    bit         elig [4];
    logic [3:0] npop;
    int         v;
    bp   = DST_FULL | DST_ALMOST_FULL;
    npop = 4'h0;
    for (int i = 0; i < 4; i++)
      elig[i] = !EMPTY_IN[i] && (m_w[i] != 0) && !(ALMOST_EMPTY_IN[i] && m_pop[i]);
    m_push = m_pd;
    m_pd   = |m_pop;
    if (!m_serve) begin
      if (!bp) begin
        for (int k = 1; k <= 4; k++) begin
          v = (m_vc + k) % 4;
          if (elig[v]) begin
            m_vc = v; m_credit = m_w[v]; m_serve = 1;
            break;
          end
        end
      end
    end else if (!elig[m_vc]) begin
      m_serve = 0;
    end else if (!bp && m_credit > 0) begin
      npop[m_vc] = 1'b1;
      m_credit--;
      if (m_credit == 0) m_serve = 0;
    end
    m_pop = npop;
    if (cfg_load) for (int i = 0; i < 4; i++) m_w[i] = int'(cfg_weights[i*WW +: WW]);
  endtask

  task automatic step();
    logic [3:0] prev_pop;
    @(posedge clk);
    #1;
    prev_pop = seen_pop;
    model_step();
    for (int v = 0; v < 4; v++) begin
      if (prev_pop[v] && cnt[v] > 0) begin
        rd_word[v] = mem[v][head[v]];
        exp_q.push_back(rd_word[v]);
        head[v] = (head[v] + 1) % 64;
        cnt[v]--;
      end
    end
    drive_fifo();
    chk("pop", 32'(pop), 32'(m_pop));
    chk("push_out", 32'(push_out), 32'(m_push));
    chk("active_vc", 32'(active_vc), 32'(m_vc));
    chk("busy", 32'(busy), 32'(m_serve));
    if (push_out === 1'b1) begin
      chk("push_has_word", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
    end
    seen_pop = pop;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_push", 32'(push_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_active_vc", 32'(active_vc), 32'd3);
    model_reset();
    seen_pop = 4'h0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    int trace [$];
    int exp_tr [$];
    int runs [$];
    int groups [$];
    int first, n1, n_other, n_push, run, want;
    bit found;

    for (int v = 0; v < 4; v++) begin head[v] = 0; cnt[v] = 0; rd_word[v] = '0; end
    drive_fifo();
    #2;

    // Default weights 1/2/3/4, all VCs deep: groups separated by one empty cycle
    do_reset();
    for (int v = 0; v < 4; v++) fill(v, 10);
    for (int i = 0; i < 34; i++) begin step(); trace.push_back(vc_of(pop)); end
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 4; v++) begin
        for (int j = 0; j <= v; j++) exp_tr.push_back(v);
        exp_tr.push_back(-1);
      end
    first = -1;
    foreach (trace[i]) if (first < 0 && trace[i] >= 0) first = i;
    chk("wrr_first_pop_found", 32'(first >= 0), 32'd1);
    if (first >= 0)
      for (int i = 0; i < exp_tr.size(); i++)
        if (first + i < trace.size()) chk("wrr_trace", 32'(trace[first + i]), 32'(exp_tr[i]));

    // VC1 disabled by weight 0
    do_reset();
    for (int v = 0; v < 4; v++) fill(v, 10);
    cfg_weights = 16'h4301; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    n1 = 0; run = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pop[1]) n1++;
      if (vc_of(pop) >= 0 && vc_of(pop) != run) groups.push_back(vc_of(pop));
      run = vc_of(pop);
    end
    chk("vc1_disabled_pops", 32'(n1), 32'd0);
    chk("wgt0_groups_seen", 32'(groups.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < groups.size(); i++)
      chk("wgt0_order", 32'(groups[i]), (i % 3 == 0) ? 32'd0 : (i % 3 == 1) ? 32'd2 : 32'd3);

    // Single almost-empty word on VC2: exactly one pop
    do_reset();
    clear_fifos();
    fill(2, 1);
    n1 = 0; n_other = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pop[2]) n1++;
      if (pop[0] | pop[1] | pop[3]) n_other++;
    end
    chk("vc2_single_pops", 32'(n1), 32'd1);
    chk("vc2_other_pops", 32'(n_other), 32'd0);
    chk("vc2_back_idle", 32'(busy), 32'd0);

    // Almost-full mid-burst on VC1 with two credits left
    do_reset();
    for (int v = 0; v < 4; v++) fill(v, 10);
    cfg_weights = 16'h4341; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    n1 = 0;
    for (int i = 0; i < 40 && n1 < 2; i++) begin step(); if (pop[1]) n1++; end
    chk("bp_reached_vc1", 32'(n1), 32'd2);
    DST_ALMOST_FULL = 1'b1;
    n1 = 0; n_push = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pop != 4'h0) n1++;
      if (push_out) n_push++;
    end
    chk("bp_no_pops", 32'(n1), 32'd0);
    chk("bp_inflight_pushes", 32'(n_push), 32'd2);
    chk("bp_holds_vc1", 32'(active_vc), 32'd1);
    DST_ALMOST_FULL = 1'b0;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin step(); if (pop[1]) n1++; end
    chk("bp_resume_vc1_pops", 32'(n1), 32'd2);

    // Weight raised while VC0 is in its weight-1 burst
    do_reset();
    for (int v = 0; v < 4; v++) fill(v, 10);
    trace.delete();
    step();
    trace.push_back(vc_of(pop));
    cfg_weights = 16'h4325; cfg_load = 1'b1;
    step();
    trace.push_back(vc_of(pop));
    cfg_load = 1'b0;
    for (int i = 0; i < 38; i++) begin step(); trace.push_back(vc_of(pop)); end
    run = 0;
    foreach (trace[i]) begin
      if (trace[i] == 0) run++;
      else if (run > 0) begin runs.push_back(run); run = 0; end
    end
    chk("vc0_runs_seen", 32'(runs.size() >= 2), 32'd1);
    if (runs.size() >= 2) begin
      chk("vc0_burst_old_wgt", 32'(runs[0]), 32'd1);
      chk("vc0_burst_new_wgt", 32'(runs[1]), 32'd5);
    end

    // Randomized traffic, backpressure and reconfiguration
    do_reset();
    clear_fifos();
    for (int i = 0; i < 400; i++) begin
      DST_ALMOST_FULL = ($urandom_range(0, 99) < 15);
      DST_FULL        = ($urandom_range(0, 99) < 5);
      for (int v = 0; v < 4; v++)
        if (cnt[v] < 2 && $urandom_range(0, 3) == 0) fill(v, $urandom_range(1, 6));
      cfg_load    = ($urandom_range(0, 49) == 0);
      cfg_weights = 16'($urandom);
      step();
    end
    cfg_load = 1'b0; DST_FULL = 1'b0; DST_ALMOST_FULL = 1'b0;

    // Reset pulse in the middle of a burst
    fill(1, 6); fill(3, 6);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin step(); if (pop != 4'h0) found = 1; end
    chk("midrst_burst_found", 32'(found), 32'd1);
    do_reset();
    want = -1;
    for (int v = 3; v >= 0; v--) if (cnt[v] > 0) want = v;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (pop != 4'h0) begin found = 1; chk("midrst_first_grant", 32'(vc_of(pop)), 32'(want)); end
    end
    chk("midrst_grant_found", 32'(found), 32'd1);

    for (int i = 0; i < 400; i++) begin
      DST_ALMOST_FULL = ($urandom_range(0, 99) < 20);
      DST_FULL        = 1'b0;
      for (int v = 0; v < 4; v++)
        if (cnt[v] < 3 && $urandom_range(0, 2) == 0) fill(v, $urandom_range(1, 8));
      cfg_load    = ($urandom_range(0, 39) == 0);
      cfg_weights = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
